// File: rtl/pong_pkg.sv
// Shared definitions for the pong game logic: FSM state encoding, LFSR constants,
// speed bounds and the LFSR step function.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   localparam int SPEED_MIN_DEF = 4;
   localparam int SPEED_MAX_DEF = 15;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/game_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR, advances every cycle; reset reloads the seed.
// Latency: state is registered, new value every cycle, no backpressure.
import pong_pkg::*;

module lfsr16 #(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] lfsr
);

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= SEED;
      else
         lfsr <= lfsr_step(lfsr);
   end

endmodule

// File: rtl/game_ctrl.sv
// Match controller: score, serve delay, rally speed-up and winner for the ball engine.
// Latency: out event at N -> score/ball_reset at N+1, serving from N+2; no backpressure.
import pong_pkg::*;

module game_ctrl #(
   parameter int SCORE_WIDTH      = 4,
   parameter int WIN_SCORE        = 9,
   parameter int SERVE_TICKS      = 2000,
   parameter int CNT_WIDTH        = 11,
   parameter int SPEED_MIN        = SPEED_MIN_DEF,
   parameter int SPEED_MAX        = SPEED_MAX_DEF,
   parameter int HITS_PER_SPEEDUP = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   out_left,
   input  logic                   out_right,
   input  logic                   paddle_hit,
   output logic                   ball_reset,
   output logic [4:0]             entropy,
   output logic [3:0]             speed,
   output logic [SCORE_WIDTH-1:0] lscore,
   output logic [SCORE_WIDTH-1:0] rscore,
   output logic                   serving,
   output logic                   game_over,
   output logic                   winner
);

   localparam int HIT_W = (HITS_PER_SPEEDUP > 1) ? $clog2(HITS_PER_SPEEDUP) : 1;

   localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
   localparam logic [CNT_WIDTH-1:0]   SERVE_LAST = CNT_WIDTH'(SERVE_TICKS - 1);
   localparam logic [HIT_W-1:0]       HIT_LAST   = HIT_W'(HITS_PER_SPEEDUP - 1);
   localparam logic [3:0]             SPD_MIN    = 4'(SPEED_MIN);
   localparam logic [3:0]             SPD_MAX    = 4'(SPEED_MAX);

   state_t                 state, state_n;
   logic [SCORE_WIDTH-1:0] lscore_n, rscore_n;
   logic [3:0]             speed_n;
   logic [HIT_W-1:0]       hit_cnt, hit_cnt_n;
   logic [CNT_WIDTH-1:0]   serve_cnt, serve_cnt_n;
   logic                   winner_n;

   logic [15:0] lfsr_state;
   logic [10:0] lfsr_unused;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .lfsr  (lfsr_state)
   );

   assign entropy     = lfsr_state[4:0];
   assign lfsr_unused = lfsr_state[15:5];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lscore    <= '0;
         rscore    <= '0;
         speed     <= SPD_MIN;
         hit_cnt   <= '0;
         serve_cnt <= '0;
         winner    <= 1'b0;
      end else begin
         state     <= state_n;
         lscore    <= lscore_n;
         rscore    <= rscore_n;
         speed     <= speed_n;
         hit_cnt   <= hit_cnt_n;
         serve_cnt <= serve_cnt_n;
         winner    <= winner_n;
      end
   end

   always_comb begin
      state_n     = state;
      lscore_n    = lscore;
      rscore_n    = rscore;
      speed_n     = speed;
      hit_cnt_n   = hit_cnt;
      serve_cnt_n = serve_cnt;
      winner_n    = winner;
      ball_reset  = 1'b1;
      serving     = 1'b0;
      game_over   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               lscore_n    = '0;
               rscore_n    = '0;
               serve_cnt_n = SERVE_LAST;
               state_n     = SERVE;
            end
         end
         SERVE: begin
            serving = 1'b1;
            if (serve_cnt == '0)
               state_n = PLAY;
            else
               serve_cnt_n = serve_cnt - 1'b1;
         end
         PLAY: begin
            ball_reset = 1'b0;
            // out events win over a simultaneous paddle hit
            if (out_left) begin
               rscore_n = rscore + 1'b1;
               state_n  = POINT;
            end else if (out_right) begin
               lscore_n = lscore + 1'b1;
               state_n  = POINT;
            end else if (paddle_hit) begin
               if (hit_cnt == HIT_LAST) begin
                  hit_cnt_n = '0;
                  if (speed < SPD_MAX)
                     speed_n = speed + 4'd1;
               end else begin
                  hit_cnt_n = hit_cnt + 1'b1;
               end
            end
         end
         POINT: begin
            speed_n   = SPD_MIN;
            hit_cnt_n = '0;
            if (lscore == WIN_VAL || rscore == WIN_VAL) begin
               winner_n = (rscore == WIN_VAL);
               state_n  = OVER;
            end else begin
               serve_cnt_n = SERVE_LAST;
               state_n     = SERVE;
            end
         end
         OVER: begin
            game_over = 1'b1;
            if (start) begin
               lscore_n    = '0;
               rscore_n    = '0;
               serve_cnt_n = SERVE_LAST;
               state_n     = SERVE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: vector table for idle/LFSR, score scoreboard,
// hand sequences for serve timing, speed-up, match end and mid-serve reset.
module tb_game_ctrl;

   localparam int SERVE_TICKS = 4;
   localparam int WIN_SCORE   = 3;
   localparam int HITS        = 4;
   localparam int SPEED_MIN   = 4;
   localparam int SPEED_MAX   = 15;

   logic       clk = 1'b0;
   logic       reset, start, out_left, out_right, paddle_hit;
   logic       ball_reset, serving, game_over, winner;
   logic [4:0] entropy;
   logic [3:0] speed;
   logic [3:0] lscore, rscore;

   game_ctrl #(
      .SCORE_WIDTH(4), .WIN_SCORE(WIN_SCORE), .SERVE_TICKS(SERVE_TICKS),
      .CNT_WIDTH(3), .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX),
      .HITS_PER_SPEEDUP(HITS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .out_left(out_left),
      .out_right(out_right), .paddle_hit(paddle_hit), .ball_reset(ball_reset),
      .entropy(entropy), .speed(speed), .lscore(lscore), .rscore(rscore),
      .serving(serving), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       exp_ball_reset;
      logic       exp_serving;
      logic [4:0] exp_entropy;
   } vec_t;

   typedef struct {
      int l;
      int r;
   } score_t;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] m_lfsr = 16'h0;
   int          exp_l  = 0;
   int          exp_r  = 0;
   int          m_speed = SPEED_MIN;
   int          m_hits  = 0;
   score_t      sb_q[$];
   vec_t        idle_vec[10];

   function automatic logic [15:0] model_next(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      m_lfsr = reset ? 16'hACE1 : model_next(m_lfsr);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_play();
      for (int i = 0; i < 20; i++) begin
         if (!ball_reset) break;
         step();
      end
      chk("reach_play", int'(ball_reset), 0);
   endtask

   task automatic score_event(input logic ol, input logic orr, input logic ph);
      score_t e, g;
      out_left = ol; out_right = orr; paddle_hit = ph;
      if (ol) exp_r++;
      else if (orr) exp_l++;
      e.l = exp_l; e.r = exp_r;
      sb_q.push_back(e);
      step();
      out_left = 1'b0; out_right = 1'b0; paddle_hit = 1'b0;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         g = sb_q.pop_front();
         chk("point_lscore", int'(lscore), g.l);
         chk("point_rscore", int'(rscore), g.r);
         chk("point_ball_reset", int'(ball_reset), 1);
      end
   endtask

   task automatic hit_pulse();
      paddle_hit = 1'b1;
      step();
      paddle_hit = 1'b0;
      m_hits++;
      if (m_hits == HITS) begin
         m_hits = 0;
         if (m_speed < SPEED_MAX) m_speed++;
      end
      chk("hit_speed", int'(speed), m_speed);
      step();
   endtask

   initial begin
      logic [15:0] m;
      m = 16'hACE1;
      for (int i = 0; i < 10; i++) begin
         m = model_next(m);
         idle_vec[i] = '{start: 1'b0, exp_ball_reset: 1'b1, exp_serving: 1'b0,
                         exp_entropy: m[4:0]};
      end

      reset = 1'b1; start = 1'b0; out_left = 1'b0; out_right = 1'b0; paddle_hit = 1'b0;
      step();
      reset = 1'b0;
      chk("rst_ball_reset", int'(ball_reset), 1);
      chk("rst_serving", int'(serving), 0);
      chk("rst_game_over", int'(game_over), 0);
      chk("rst_speed", int'(speed), SPEED_MIN);
      chk("rst_lscore", int'(lscore), 0);
      chk("rst_rscore", int'(rscore), 0);
      chk("rst_winner", int'(winner), 0);
      chk("rst_entropy", int'(entropy), 5'h01);

      for (int i = 0; i < 10; i++) begin
         start = idle_vec[i].start;
         step();
         chk("idle_ball_reset", int'(ball_reset), int'(idle_vec[i].exp_ball_reset));
         chk("idle_serving", int'(serving), int'(idle_vec[i].exp_serving));
         chk("idle_entropy", int'(entropy), int'(idle_vec[i].exp_entropy));
      end

      // serve timing: serving for exactly SERVE_TICKS cycles
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= SERVE_TICKS; c++) begin
         chk("serve_serving", int'(serving), 1);
         chk("serve_ball_reset", int'(ball_reset), 1);
         step();
      end
      chk("play_ball_reset", int'(ball_reset), 0);
      chk("play_serving", int'(serving), 0);
      chk("play_entropy", int'(entropy), int'(m_lfsr[4:0]));

      for (int i = 0; i < 9; i++) hit_pulse();
      chk("speed_after9", int'(speed), 6);
      for (int i = 0; i < 3; i++) hit_pulse();
      chk("speed_after12", int'(speed), 7);
      for (int i = 0; i < 47; i++) hit_pulse();
      chk("speed_saturated", int'(speed), SPEED_MAX);

      // all three events together: only out_left counts
      score_event(1'b1, 1'b1, 1'b1);
      step();
      chk("point_speed_reset", int'(speed), SPEED_MIN);
      chk("point_to_serve", int'(serving), 1);
      wait_play();

      for (int p = 0; p < WIN_SCORE; p++) begin
         score_event(1'b0, 1'b1, 1'b0);
         if (p < WIN_SCORE - 1) wait_play();
      end
      step();
      chk("over_game_over", int'(game_over), 1);
      chk("over_winner", int'(winner), 0);
      chk("over_ball_reset", int'(ball_reset), 1);
      out_left = 1'b1; out_right = 1'b1;
      for (int i = 0; i < 3; i++) step();
      out_left = 1'b0; out_right = 1'b0;
      chk("over_lscore_hold", int'(lscore), WIN_SCORE);
      chk("over_rscore_hold", int'(rscore), 1);
      chk("over_still", int'(game_over), 1);

      start = 1'b1;
      step();
      exp_l = 0; exp_r = 0;
      chk("restart_lscore", int'(lscore), 0);
      chk("restart_rscore", int'(rscore), 0);
      chk("restart_serving", int'(serving), 1);
      chk("restart_game_over", int'(game_over), 0);
      for (int c = 2; c <= SERVE_TICKS; c++) begin
         step();
         chk("restart_serve_hold", int'(serving), 1);
      end
      step();
      chk("start_ignored_play", int'(ball_reset), 0);
      start = 1'b0;

      // reset in the second SERVE cycle (serve_cnt==2)
      score_event(1'b1, 1'b0, 1'b0);
      step();
      step();
      chk("pre_reset_serving", int'(serving), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_serving", int'(serving), 0);
      chk("mrst_ball_reset", int'(ball_reset), 1);
      chk("mrst_entropy", int'(entropy), 5'h01);
      chk("mrst_rscore", int'(rscore), 0);
      chk("mrst_speed", int'(speed), SPEED_MIN);
      step();
      chk("mrst_idle_hold", int'(serving), 0);
      chk("mrst_entropy_next", int'(entropy), int'(m_lfsr[4:0]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Match-level controller that consumes the ball engine's event outputs (`out_left`, `out_right`, `paddle_hit`).
- Drives the ball engine's control inputs (`ball_reset`, `entropy`, `speed`).
- Keeps score, times the serve delay, ramps ball speed on rallies and declares the winner.
- Runs on the same 2 kHz game tick clock as the ball engine.

Parameters:
- SCORE_WIDTH, 4, width of each score counter.
- WIN_SCORE, 9, points needed to win; must be ≤ 2^SCORE_WIDTH-1.
- SERVE_TICKS, 2000, number of cycles spent in SERVE (1 s at 2 kHz); ≥ 2.
- CNT_WIDTH, 11, serve-counter width; must hold SERVE_TICKS-1.
- SPEED_MIN, 4, ball speed at each serve.
- SPEED_MAX, 15, speed ceiling (4-bit).
- HITS_PER_SPEEDUP, 4, paddle hits per +1 speed step.

Ports:
- clk  in  1  game tick clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start/restart request, level-sampled each cycle
- out_left  in  1  ball left the left edge (point to right player)
- out_right  in  1  ball left the right edge (point to left player)
- paddle_hit  in  1  ball struck a paddle this cycle
- ball_reset  out  1  hold the ball centred and re-aim it
- entropy  out  5  random bits for serve direction/bounce
- speed  out  4  current ball speed
- lscore  out  SCORE_WIDTH  left player score
- rscore  out  SCORE_WIDTH  right player score
- serving  out  1  high while in SERVE
- game_over  out  1  high while in OVER
- winner  out  1  0 = left won, 1 = right won; valid while game_over

Behaviour:
- Clock, reset, outputs:
  - One clock. All state is registered.
  - Reset is synchronous and active-high. It forces:
    - state=IDLE, lscore=rscore=0, speed=SPEED_MIN, hit_cnt=0
    - serve_cnt=0, winner=0, LFSR=16'hACE1
  - `ball_reset`, `serving` and `game_over` are decoded from the state register (Moore outputs). After reset: ball_reset=1, serving=0, game_over=0.
- LFSR:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Advances every cycle in every state except during reset.
  - entropy = lfsr[4:0].
  - The LFSR never reaches the all-zero state.
- States: IDLE, SERVE, PLAY, POINT, OVER.
  - IDLE:
    - ball_reset=1.
    - On start=1: clear both scores, load serve_cnt=SERVE_TICKS-1, go to SERVE.
  - SERVE:
    - ball_reset=1, serving=1.
    - Decrement serve_cnt each cycle.
    - At serve_cnt==0: go to PLAY.
    - SERVE lasts exactly SERVE_TICKS cycles.
    - Events on out_left, out_right and paddle_hit are ignored.
  - PLAY:
    - ball_reset=0.
    - Priority order: out_left > out_right > paddle_hit.
    - out_left: rscore+1, go to POINT.
    - out_right (with out_left=0): lscore+1, go to POINT.
    - paddle_hit alone:
      - if hit_cnt==HITS_PER_SPEEDUP-1: hit_cnt=0 and speed=min(speed+1, SPEED_MAX);
      - else hit_cnt+1.
    - A paddle_hit in the same cycle as an out event is discarded.
  - POINT (1 cycle):
    - ball_reset=1. Reset speed to SPEED_MIN and hit_cnt to 0.
    - If lscore==WIN_SCORE or rscore==WIN_SCORE: winner=(rscore==WIN_SCORE), go to OVER.
    - Otherwise load serve_cnt=SERVE_TICKS-1 and go to SERVE.
  - OVER:
    - ball_reset=1, game_over=1. Scores and winner hold.
    - On start=1: clear scores, load serve_cnt, go to SERVE.
- Latency:
  - Out event in cycle N → score visible and ball_reset=1 at N+1.
  - serving=1 from N+2.
  - ball_reset falls at N+2+SERVE_TICKS.
- Scores never exceed WIN_SCORE, because the game ends at WIN_SCORE.
- start held high through OVER restarts immediately. start while in SERVE or PLAY is ignored.
- speed is held while saturated at SPEED_MAX; it never wraps.
- reset asserted mid-rally or mid-serve aborts to IDLE on the next edge with all reset values.

Decomposition:
- Shared package `pong_pkg`:
  - state encoding enum (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4)
  - LFSR seed 16'hACE1 and mask 16'hB400
  - speed bounds
- One sub-module, `lfsr16`: clk, reset, 16-bit state out. It is reused by any future noise or sound generator.

Test Plan:
- Reset then idle: reset 1 cycle, start=0 for 10 cycles → ball_reset=1, speed=4, scores 0/0, entropy follows the LFSR sequence from 16'hACE1 (first value 5'h01).
- Serve timing (SERVE_TICKS=4): pulse start at cycle 0 → serving=1 for cycles 1–4, ball_reset=0 from cycle 5.
- Speedup: 9 single-cycle paddle_hit pulses in PLAY → speed 4→6 after hits 4 and 8, hit_cnt=1; 50 further hits → speed saturates at 15.
- Simultaneous events: out_left=out_right=paddle_hit=1 in one PLAY cycle → rscore+1 only, lscore unchanged, speed reset to 4 in POINT.
- Match end (WIN_SCORE=3): three out_right events → lscore=3, game_over=1, winner=0, later events ignored; start=1 → scores 0/0, serving=1 next cycle.
- Mid-serve reset: reset during SERVE with serve_cnt=2 → next cycle IDLE, serving=0, ball_reset=1, LFSR reloaded to 16'hACE1.
